// File: rtl/upcounter_pkg.sv
// Shared types and defaults for the up-counter run/stop/clear controller.
// Code 2'd3 has no name and is handled as STOP by the controller's case default.
package upcounter_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int DEFAULT_CLK_DIV   = 10_000_000;
  localparam int DEFAULT_DB_CYCLES = 1_000_000;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, stability counter, and a
// single-cycle pulse on each accepted press (release produces nothing).
module button_debounce
  import upcounter_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= i_btn;
      sync_2 <= sync_1;
    end
  end

  // The level only moves after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync_2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      level  <= sync_2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level_d <= 1'b0;
      o_press <= 1'b0;
    end else begin
      level_d <= level;
      o_press <= level & ~level_d;
    end
  end

endmodule

// File: rtl/upcounter_ctrl.sv
// Run/stop/clear controller: debounced buttons drive a three-state FSM, and a
// prescaler turns RUN time into single-cycle count-enable ticks on i_clk.
module upcounter_ctrl
  import upcounter_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_run,
  input  logic i_btn_clear,
  output logic o_tick,
  output logic o_clear,
  output logic o_run
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic          run_press;
  logic          clear_press;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_run),
    .o_press (run_press)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_clear),
    .o_press (clear_press)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_STOP;
      presc <= '0;
    end else begin
      state <= state_next;
      presc <= presc_next;
    end
  end

  // Clear takes priority over run; the CLEAR cycle ignores both buttons.
  // STOP holds the prescaler so a resume keeps the tick phase.
  always_comb begin
    state_next = state;
    presc_next = presc;
    case (state)
      ST_RUN: begin
        presc_next = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        if (clear_press)    state_next = ST_CLEAR;
        else if (run_press) state_next = ST_STOP;
      end
      ST_CLEAR: begin
        presc_next = '0;
        state_next = ST_STOP;
      end
      default: begin
        if (clear_press)    state_next = ST_CLEAR;
        else if (run_press) state_next = ST_RUN;
        else                state_next = ST_STOP;
      end
    endcase
  end

  assign o_run   = (state == ST_RUN);
  assign o_clear = (state == ST_CLEAR);
  assign o_tick  = (state == ST_RUN) && (presc == PRESC_LAST);

endmodule

// File: tb/tb_upcounter_ctrl.sv
// Randomized and directed bench for upcounter_ctrl, checked cycle by cycle
// against a behavioural model of button conditioning, run mode and tick phase.
module tb_upcounter_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int DB_CYCLES = 3;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_btn_run;
  logic i_btn_clear;
  logic o_tick;
  logic o_clear;
  logic o_run;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state; index 0 is the run button, index 1 the clear button.
  bit [1:0] m_hist[$];
  bit [1:0] m_level;
  int       m_streak[2];
  bit [1:0] m_rise;
  bit [1:0] m_press;
  bit       m_running;
  bit       m_clearing;
  int       m_phase;

  upcounter_ctrl #(.CLK_DIV(CLK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_btn_run   (i_btn_run),
    .i_btn_clear (i_btn_clear),
    .o_tick      (o_tick),
    .o_clear     (o_clear),
    .o_run       (o_run)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_hist = {2'b00, 2'b00};
    m_level = 2'b00;
    m_streak[0] = 0;
    m_streak[1] = 0;
    m_rise = 2'b00;
    m_press = 2'b00;
    m_running = 1'b0;
    m_clearing = 1'b0;
    m_phase = 0;
  endtask

  // One clock edge of the reference behaviour, with raw buttons sampled there.
  task automatic modelStep(input bit run_raw, input bit clr_raw);
    bit [1:0] synced;
    bit [1:0] rise_now;
    bit       next_running;
    bit       next_clearing;
    synced = m_hist.pop_front();
    m_hist.push_back({clr_raw, run_raw});

    if (m_clearing) begin
      next_running = 1'b0;
      next_clearing = 1'b0;
    end else if (m_press[1]) begin
      next_running = 1'b0;
      next_clearing = 1'b1;
    end else if (m_press[0]) begin
      next_running = !m_running;
      next_clearing = 1'b0;
    end else begin
      next_running = m_running;
      next_clearing = 1'b0;
    end
    if (m_running) m_phase = (m_phase + 1) % CLK_DIV;
    if (m_clearing) m_phase = 0;
    m_running = next_running;
    m_clearing = next_clearing;

    m_press = m_rise;
    rise_now = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (synced[b] != m_level[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DB_CYCLES) begin
          m_level[b] = synced[b];
          m_streak[b] = 0;
          rise_now[b] = synced[b];
        end
      end else begin
        m_streak[b] = 0;
      end
    end
    m_rise = rise_now;
  endtask

  // Called at a falling edge; drives one cycle and checks after the rising edge.
  task automatic applyStimulus(input bit run, input bit clr);
    i_btn_run = run;
    i_btn_clear = clr;
    @(posedge i_clk);
    modelStep(run, clr);
    #1;
    checkOutput("run", o_run, m_running);
    checkOutput("clear", o_clear, m_clearing);
    checkOutput("tick", o_tick, (m_running && m_phase == CLK_DIV - 1));
    checkOutput("clear_tick_excl", (o_clear & o_tick), 0);
    @(negedge i_clk);
  endtask

  task automatic repeatStimulus(input bit run, input bit clr, input int n);
    for (int i = 0; i < n; i++) applyStimulus(run, clr);
  endtask

  // Asynchronous reset pulse placed between clock edges; buttons keep their level.
  task automatic pulseReset();
    #2 i_reset = 1'b1;
    #1;
    checkOutput("rst_run", o_run, 0);
    checkOutput("rst_clear", o_clear, 0);
    checkOutput("rst_tick", o_tick, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    modelReset();
  endtask

  initial begin
    int rise_at;
    i_reset = 1'b1;
    i_btn_run = 1'b0;
    i_btn_clear = 1'b0;
    modelReset();
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("reset_run", o_run, 0);
    checkOutput("reset_clear", o_clear, 0);
    checkOutput("reset_tick", o_tick, 0);
    i_reset = 1'b0;

    repeatStimulus(1'b0, 1'b0, 20);

    rise_at = -1;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (rise_at < 0 && o_run === 1'b1) rise_at = k;
    end
    checkOutput("run_latency", rise_at, 7);
    repeatStimulus(1'b0, 1'b0, 14);

    // Short glitch while running, then stop, idle, resume.
    repeatStimulus(1'b1, 1'b0, 2);
    repeatStimulus(1'b0, 1'b0, 8);
    repeatStimulus(1'b1, 1'b0, 5);
    repeatStimulus(1'b0, 1'b0, 12);
    repeatStimulus(1'b1, 1'b0, 5);
    repeatStimulus(1'b0, 1'b0, 13);

    // Both buttons together from RUN: clear must win.
    repeatStimulus(1'b1, 1'b1, 6);
    repeatStimulus(1'b0, 1'b0, 10);

    // Back to RUN, then reset with the run button held through it.
    repeatStimulus(1'b1, 1'b0, 6);
    repeatStimulus(1'b0, 1'b0, 9);
    repeatStimulus(1'b1, 1'b0, 3);
    pulseReset();
    repeatStimulus(1'b1, 1'b0, 12);
    repeatStimulus(1'b0, 1'b0, 10);

    for (int seg = 0; seg < 80; seg++) begin
      bit r;
      bit c;
      r = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) pulseReset();
      repeatStimulus(r, c, int'($urandom_range(1, 9)));
    end
    repeatStimulus(1'b0, 1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
